// File: rtl/puzzle_seq_ctrl_pkg.sv
// Shared Puzzle types and constants: controller state encoding, default grid size and cell width.
package puzzle_pkg;

    localparam int unsigned PUZZLE_NUM_CELLS = 81;
    localparam int unsigned PUZZLE_DATA_W    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        CHECK = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/puzzle_seq_ctrl_if.sv
// Host byte stream (valid/ready) plus the solver load/process strobes and verdict.
interface puzzle_seq_ctrl_if
    import puzzle_pkg::*;
#(
    parameter int unsigned DATA_W = PUZZLE_DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] grid_input;
    logic              enable;
    logic              enable_process;
    logic              result;

    // master: the sequencer; slave: host plus solver around it
    modport master (
        input  in_data, in_valid, result,
        output in_ready, grid_input, enable, enable_process
    );

    modport slave (
        output in_data, in_valid, result,
        input  in_ready, grid_input, enable, enable_process
    );

endinterface

// File: rtl/puzzle_cell_cnt.sv
// Up-counter with synchronous clear and increment; flags when the count sits at LAST.
module puzzle_cell_cnt #(
    parameter int unsigned W    = 4,
    parameter int unsigned LAST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_last_c = (r_cnt == W'(LAST));

endmodule

// File: rtl/puzzle_seq_ctrl.sv
// Puzzle sequencer: loads NUM_CELLS grid cells, then NUM_CELLS solution cells, then latches the verdict.
// Optional stall watchdog when PUZZLE_SEQ_TIMEOUT_EN is defined (err otherwise stays 0).
module puzzle_seq_ctrl
    import puzzle_pkg::*;
#(
    parameter int unsigned NUM_CELLS  = PUZZLE_NUM_CELLS,
    parameter int unsigned DATA_W     = PUZZLE_DATA_W,
    parameter int unsigned RESULT_LAT = 2
`ifdef PUZZLE_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    puzzle_seq_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              err
);

    localparam int unsigned CELL_W = $clog2(NUM_CELLS + 1);
    localparam int unsigned LAT_W  = $clog2(RESULT_LAT + 1);

    state_e            r_state;
    logic [DATA_W-1:0] r_grid;
    logic              r_enable;
    logic              r_enable_process;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_err;

    logic w_in_ready;
    logic w_accept;
    logic w_cell_last;
    logic w_cell_clr;
    logic w_lat_last;
    logic w_lat_clr;
    logic w_timeout;

    assign w_in_ready = (r_state == LOAD) || (r_state == CHECK);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_cell_clr = abort || (r_state == IDLE) || (w_accept && w_cell_last);
    assign w_lat_clr  = abort || (r_state != WAIT);

    puzzle_cell_cnt #(
        .W    (CELL_W),
        .LAST (NUM_CELLS - 1)
    ) u_cell_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_cell_clr),
        .i_inc    (w_accept),
        .o_last_c (w_cell_last)
    );

    // Counts WAIT cycles since the last solution cell reached grid_input
    puzzle_cell_cnt #(
        .W    (LAT_W),
        .LAST (RESULT_LAT - 1)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_lat_clr),
        .i_inc    (r_state == WAIT),
        .o_last_c (w_lat_last)
    );

`ifdef PUZZLE_SEQ_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic w_stall_last;

    puzzle_cell_cnt #(
        .W    (STALL_W),
        .LAST (TIMEOUT_CYC - 1)
    ) u_stall_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (abort || w_accept || !w_in_ready),
        .i_inc    (w_in_ready && !w_accept),
        .o_last_c (w_stall_last)
    );

    assign w_timeout = w_in_ready && !w_accept && w_stall_last;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_grid           <= '0;
            r_enable         <= 1'b0;
            r_enable_process <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err            <= 1'b0;
        end else if (abort) begin
            r_state          <= IDLE;
            r_enable         <= 1'b0;
            r_enable_process <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            r_enable         <= 1'b0;
            r_enable_process <= 1'b0;
            r_done           <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_grid   <= bus.in_data;
                        r_enable <= 1'b1;
                        if (w_cell_last) r_state <= GAP;
                    end
                end
                GAP: r_state <= CHECK;
                CHECK: begin
                    if (w_accept) begin
                        r_grid           <= bus.in_data;
                        r_enable_process <= 1'b1;
                        if (w_cell_last) r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_lat_last) begin
                        r_pass  <= bus.result;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            // Stalled host: give up with an error verdict
            if (w_timeout) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.grid_input     = r_grid;
    assign bus.enable         = r_enable;
    assign bus.enable_process = r_enable_process;
    assign busy               = r_busy;
    assign done               = r_done;
    assign pass               = r_pass;
    assign err                = r_err;

endmodule

// File: tb/tb_puzzle_seq_ctrl.sv
// Directed bench for puzzle_seq_ctrl with NUM_CELLS=4, RESULT_LAT=2 (TIMEOUT_CYC=8 with PUZZLE_SEQ_TIMEOUT_EN).
module tb_puzzle_seq_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned RL = 2;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic pass;
    logic err;

    int vecs = 0;
    int errs = 0;

    puzzle_seq_ctrl_if #(.DATA_W(DW)) bus ();

    puzzle_seq_ctrl #(
        .NUM_CELLS  (N),
        .DATA_W     (DW),
        .RESULT_LAT (RL)
`ifdef PUZZLE_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .pass  (pass),
        .err   (err)
    );

    always #5 clk = ~clk;

    // One full sequence; the bench tracks the expected phase itself and checks every cycle.
    // phase: 0 idle, 1 load, 2 gap, 3 check, 4 wait, 5 done
    task automatic run_seq(input string name, input bit bubbles, input bit verdict,
                           input int abort_at, input bit start_in_done);
        int phase = 1;
        int prev_phase = 0;
        int cnt = 0;
        int wcnt = 0;
        int n_en = 0;
        int n_ep = 0;
        int cyc = 0;
        int last_ep_cyc = 0;
        bit acc = 1'b0;
        bit prev_acc = 1'b0;
        bit vtog = 1'b1;
        bit fin = 1'b0;
        bit aborted = 1'b0;
        bit have_grid = 1'b0;
        bit exp_pass = 1'b0;
        logic [DW-1:0] exp_grid = '0;
        bus.in_valid = 1'b0;
        bus.result   = ~verdict;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 100) begin
            vecs++;
            if (bus.enable !== (prev_acc && prev_phase == 1)) begin
                errs++; $display("FAIL %s enable cyc%0d: got %b want %b", name, cyc, bus.enable, prev_acc && prev_phase == 1);
            end
            vecs++;
            if (bus.enable_process !== (prev_acc && prev_phase == 3)) begin
                errs++; $display("FAIL %s enable_process cyc%0d: got %b want %b", name, cyc, bus.enable_process, prev_acc && prev_phase == 3);
            end
            vecs++;
            if (bus.enable === 1'b1 && bus.enable_process === 1'b1) begin
                errs++; $display("FAIL %s strobes cyc%0d: got both 1 want at most one", name, cyc);
            end
            if (have_grid) begin
                vecs++;
                if (bus.grid_input !== exp_grid) begin
                    errs++; $display("FAIL %s grid_input cyc%0d: got %h want %h", name, cyc, bus.grid_input, exp_grid);
                end
            end
            vecs++;
            if (bus.in_ready !== (phase == 1 || phase == 3)) begin
                errs++; $display("FAIL %s in_ready cyc%0d: got %b want %b", name, cyc, bus.in_ready, phase == 1 || phase == 3);
            end
            vecs++;
            if (busy !== (phase >= 1 && phase <= 4)) begin
                errs++; $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy, phase >= 1 && phase <= 4);
            end
            vecs++;
            if (done !== (phase == 5)) begin
                errs++; $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done, phase == 5);
            end
            vecs++;
            if (pass !== exp_pass) begin
                errs++; $display("FAIL %s pass cyc%0d: got %b want %b", name, cyc, pass, exp_pass);
            end
            vecs++;
            if (err !== 1'b0) begin
                errs++; $display("FAIL %s err cyc%0d: got %b want 0", name, cyc, err);
            end
            n_en += int'(bus.enable === 1'b1);
            n_ep += int'(bus.enable_process === 1'b1);
            if (bus.enable_process === 1'b1) last_ep_cyc = cyc;
            if (done === 1'b1) begin
                vecs++;
                if (cyc - last_ep_cyc != int'(RL)) begin
                    errs++; $display("FAIL %s done_latency: got %0d want %0d", name, cyc - last_ep_cyc, RL);
                end
            end
            if (phase == 0) begin
                fin = 1'b1;
            end else begin
                acc = 1'b0;
                start = (phase == 5) && start_in_done;
                if (phase == 3 && cnt == abort_at) begin
                    abort = 1'b1;
                    bus.in_valid = 1'b0;
                end else if (phase == 1 || phase == 3) begin
                    bus.in_valid = bubbles ? vtog : 1'b1;
                    vtog = ~vtog;
                    bus.in_data = (phase == 1) ? 8'h30 + 8'(cnt) : 8'hC0 + 8'(cnt * 5);
                    acc = bus.in_valid;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 8'hEE;
                end
                bus.result = (phase == 4 && wcnt >= int'(RL) - 1) ? verdict : ~verdict;
                prev_acc = acc;
                prev_phase = phase;
                if (abort) begin
                    phase = 0;
                    aborted = 1'b1;
                    exp_pass = 1'b0;
                end else begin
                    case (phase)
                        1, 3: if (acc) begin
                            exp_grid = bus.in_data;
                            have_grid = 1'b1;
                            cnt++;
                            if (cnt == int'(N)) begin
                                phase = (phase == 1) ? 2 : 4;
                                cnt = 0;
                                wcnt = 0;
                            end
                        end
                        2: phase = 3;
                        4: begin
                            wcnt++;
                            if (wcnt == int'(RL)) begin
                                phase = 5;
                                exp_pass = verdict;
                            end
                        end
                        default: phase = 0;
                    endcase
                end
                @(negedge clk);
                abort = 1'b0;
                cyc++;
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        vecs++;
        if (!fin) begin
            errs++; $display("FAIL %s cycle_budget: got no return to idle want idle within 100 cycles", name);
        end
        vecs++;
        if (n_en != int'(N)) begin
            errs++; $display("FAIL %s enable_count: got %0d want %0d", name, n_en, N);
        end
        vecs++;
        if (n_ep != (aborted ? abort_at : int'(N))) begin
            errs++; $display("FAIL %s enable_process_count: got %0d want %0d", name, n_ep, aborted ? abort_at : int'(N));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.result = 1'b0;
        #3;
        vecs++; if (bus.grid_input !== 8'h00) begin errs++; $display("FAIL reset grid_input: got %h want 00", bus.grid_input); end
        vecs++; if (bus.enable !== 1'b0) begin errs++; $display("FAIL reset enable: got %b want 0", bus.enable); end
        vecs++; if (bus.enable_process !== 1'b0) begin errs++; $display("FAIL reset enable_process: got %b want 0", bus.enable_process); end
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset done: got %b want 0", done); end
        vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL reset pass: got %b want 0", pass); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset err: got %b want 0", err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_pass();
        run_seq("basic_pass", 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_fail_verdict();
        run_seq("fail_verdict", 1'b0, 1'b0, -1, 1'b0);
    endtask

    task automatic test_bubbles();
        run_seq("bubbles", 1'b1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_abort();
        run_seq("abort", 1'b0, 1'b1, 2, 1'b0);
        repeat (3) begin
            @(negedge clk);
            vecs++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errs++; $display("FAIL abort_idle: got done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_seq("after_abort", 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_rst_mid_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        @(negedge clk);
        bus.in_data = 8'h6B;
        @(negedge clk);
        vecs++;
        if (bus.enable !== 1'b1 || bus.grid_input !== 8'h6B) begin
            errs++; $display("FAIL rst_mid pre: got en=%b grid=%h want 1 6b", bus.enable, bus.grid_input);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vecs++; if (bus.grid_input !== 8'h00) begin errs++; $display("FAIL rst_mid grid_input: got %h want 00", bus.grid_input); end
        vecs++; if (bus.enable !== 1'b0) begin errs++; $display("FAIL rst_mid enable: got %b want 0", bus.enable); end
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_mid in_ready: got %b want 0", bus.in_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        run_seq("after_rst", 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq("b2b_first", 1'b0, 1'b1, -1, 1'b1);
        run_seq("b2b_second", 1'b1, 1'b0, -1, 1'b0);
    endtask

`ifdef PUZZLE_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h01;
        @(negedge clk);
        bus.in_data = 8'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= int'(TO); i++) begin
            @(negedge clk);
            vecs++;
            if (done !== (i == int'(TO)) || err !== (i == int'(TO)) || busy !== (i != int'(TO))) begin
                errs++; $display("FAIL timeout stall%0d: got done=%b err=%b busy=%b want %b %b %b", i, done, err, busy,
                                 i == int'(TO), i == int'(TO), i != int'(TO));
            end
        end
        vecs++; if (pass !== 1'b0) begin errs++; $display("FAIL timeout pass: got %b want 0", pass); end
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL timeout in_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        vecs++;
        if (done !== 1'b0 || err !== 1'b1) begin
            errs++; $display("FAIL timeout after: got done=%b err=%b want 0 1", done, err);
        end
        run_seq("after_timeout", 1'b0, 1'b1, -1, 1'b0);
    endtask
`else
    task automatic test_stall();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h01;
        @(negedge clk);
        bus.in_data = 8'h02;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        vecs++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || bus.in_ready !== 1'b1 || bus.enable !== 1'b0) begin
            errs++; $display("FAIL stall: got busy=%b done=%b err=%b rdy=%b en=%b want 1 0 0 1 0",
                             busy, done, err, bus.in_ready, bus.enable);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL stall_abort: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_pass();
        test_fail_verdict();
        test_bubbles();
        test_abort();
        test_rst_mid_load();
        test_back_to_back();
`ifdef PUZZLE_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want end before 200000");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
